// File: rtl/ppu_sram_pkg.sv
// ppu_sram_pkg: FSM, requester and lane encodings shared by the VRAM arbiter
package ppu_sram_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WSET, ST_WPUL, ST_WHLD} state_t;
  typedef enum logic {REQ_RND, REQ_CPU} req_t;
  typedef enum logic {LANE_LO, LANE_HI} lane_t;
endpackage

// File: rtl/ppu_sram_arb_if.sv
// ppu_sram_arb_if: render, CPU and SRAM buses of the VRAM arbiter
interface ppu_sram_arb_if;
  logic        rnd_req;
  logic [11:0] rnd_addr;
  logic        rnd_gnt;
  logic        rnd_rvalid;
  logic [15:0] rnd_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic [11:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  modport master (
    output rnd_req, rnd_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata,
    input  rnd_gnt, rnd_rvalid, rnd_rdata, cpu_gnt, cpu_done, cpu_rdata,
           sram_addr, sram_wdata, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n
  );
  modport slave (
    input  rnd_req, rnd_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata,
    output rnd_gnt, rnd_rvalid, rnd_rdata, cpu_gnt, cpu_done, cpu_rdata,
           sram_addr, sram_wdata, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/ppu_sram_strobe_tmr.sv
// ppu_sram_strobe_tmr: down-counter timing a strobe phase, flags its final cycle
module ppu_sram_strobe_tmr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         last
);
  logic [W-1:0] cnt;
  // Load at phase start, then count down and rest at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= load ? val : (cnt != '0 ? cnt - 1'b1 : cnt);
  end
  assign last = cnt == '0;
endmodule

// File: rtl/ppu_sram_arb.sv
// ppu_sram_arb: VRAM SRAM sharing between render and CPU; PPU_SRAM_ARB_STAT_EN adds grant statistics
module ppu_sram_arb
  import ppu_sram_pkg::*;
#(
  parameter int RD_CYC     = 2,
  parameter int WR_CYC     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic i_ppu_clk,
  input logic i_ppu_rst,
  ppu_sram_arb_if.slave bus
`ifdef PPU_SRAM_ARB_STAT_EN
  ,
  output logic [15:0] o_stat_rnd_cnt,
  output logic [15:0] o_stat_cpu_cnt,
  output logic [7:0]  o_stat_cpu_wmax
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2((RD_CYC > WR_CYC ? RD_CYC : WR_CYC) + 1);
  state_t        state, state_nx;
  req_t          who;
  lane_t         lane;
  logic [SW-1:0] starve_cnt;
  logic [11:0]   addr;
  logic [15:0]   wdata;
  logic [15:0]   rnd_rdata;
  logic [7:0]    cpu_rdata;
  logic          rnd_rv, cpu_rd_done;
  logic          idle, rnd_win, cpu_win, last, rd_end;
  assign idle    = state == ST_IDLE && !i_ppu_rst;
  assign rnd_win = idle && bus.rnd_req && (int'(starve_cnt) < STARVE_MAX || !bus.cpu_req);
  assign cpu_win = idle && bus.cpu_req && !rnd_win;
  assign rd_end  = state == ST_RD && last;
  ppu_sram_strobe_tmr #(.W(TW)) u_tmr (
    .clk  (i_ppu_clk),
    .rst  (i_ppu_rst),
    .load (rnd_win || (cpu_win && !bus.cpu_we) || state == ST_WSET),
    .val  (state == ST_WSET ? TW'(WR_CYC - 1) : TW'(RD_CYC - 1)),
    .last (last)
  );
  // Access sequencing and strobe decode from the current phase and latched requester
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = (cpu_win && bus.cpu_we) ? ST_WSET : (rnd_win || cpu_win) ? ST_RD : ST_IDLE;
      ST_RD:   state_nx = last ? ST_IDLE : ST_RD;
      ST_WSET: state_nx = ST_WPUL;
      ST_WPUL: state_nx = last ? ST_WHLD : ST_WPUL;
      default: state_nx = ST_IDLE;
    endcase
    bus.sram_oe_n = state != ST_RD;
    bus.sram_we_n = state != ST_WPUL;
    bus.sram_ub_n = !(state != ST_IDLE && (who == REQ_RND || lane == LANE_HI));
    bus.sram_lb_n = !(state != ST_IDLE && (who == REQ_RND || lane == LANE_LO));
  end
  // State, starvation guard, latched request and read-data capture
  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      state       <= ST_IDLE;
      who         <= REQ_RND;
      lane        <= LANE_LO;
      starve_cnt  <= '0;
      addr        <= '0;
      wdata       <= '0;
      rnd_rdata   <= '0;
      cpu_rdata   <= '0;
      rnd_rv      <= 1'b0;
      cpu_rd_done <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= (!bus.cpu_req || cpu_win) ? '0 :
                    (rnd_win && int'(starve_cnt) < STARVE_MAX) ? starve_cnt + 1'b1 : starve_cnt;
      if (rnd_win) begin
        who  <= REQ_RND;
        addr <= bus.rnd_addr;
      end
      if (cpu_win) begin
        who   <= REQ_CPU;
        addr  <= bus.cpu_addr[12:1];
        lane  <= lane_t'(bus.cpu_addr[0]);
        wdata <= {bus.cpu_wdata, bus.cpu_wdata};
      end
      rnd_rv      <= rd_end && who == REQ_RND;
      cpu_rd_done <= rd_end && who == REQ_CPU;
      if (rd_end && who == REQ_RND) rnd_rdata <= bus.sram_rdata;
      if (rd_end && who == REQ_CPU) cpu_rdata <= lane == LANE_HI ? bus.sram_rdata[15:8] : bus.sram_rdata[7:0];
    end
  end
  assign bus.rnd_gnt    = rnd_win;
  assign bus.cpu_gnt    = cpu_win;
  assign bus.rnd_rvalid = rnd_rv;
  assign bus.rnd_rdata  = rnd_rdata;
  assign bus.cpu_done   = cpu_rd_done || state == ST_WHLD;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.sram_addr  = addr;
  assign bus.sram_wdata = wdata;
`ifdef PPU_SRAM_ARB_STAT_EN
  logic [7:0] cpu_wait;
  // Grant counters and worst CPU wait from request to grant
  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      o_stat_rnd_cnt  <= '0;
      o_stat_cpu_cnt  <= '0;
      o_stat_cpu_wmax <= '0;
      cpu_wait        <= '0;
    end else begin
      if (rnd_win) o_stat_rnd_cnt <= o_stat_rnd_cnt + 16'd1;
      if (cpu_win) o_stat_cpu_cnt <= o_stat_cpu_cnt + 16'd1;
      if (cpu_win && cpu_wait > o_stat_cpu_wmax) o_stat_cpu_wmax <= cpu_wait;
      cpu_wait <= (!bus.cpu_req || cpu_win) ? '0 : (cpu_wait == 8'hFF ? cpu_wait : cpu_wait + 8'd1);
    end
  end
`endif
endmodule
